// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared constants and sizing helpers for the performance-event aggregator
//
// Purpose: event index constants for the CPU complex and width helpers used by
//          perf_event_accum and perf_aggregator.
// Contents:
//   EVT_* / NUM_PERF_EVENTS : event class indices
//   inc_width(n_cores)      : bits needed to hold a per-cycle popcount of n_cores pulses
//   sel_width(n_events)     : bits of the shadow read index (at least 1)
package perf_pkg;

  localparam int EVT_CYCLE       = 0;
  localparam int EVT_INSTR       = 1;
  localparam int EVT_CACHE_HIT   = 2;
  localparam int EVT_CACHE_MISS  = 3;
  localparam int EVT_BR_TAKEN    = 4;
  localparam int EVT_BR_MISPRED  = 5;
  localparam int NUM_PERF_EVENTS = 6;

  function automatic int inc_width(input int n_cores);
    return (n_cores < 1) ? 1 : $clog2(n_cores + 1);
  endfunction

  function automatic int sel_width(input int n_events);
    return (n_events > 1) ? $clog2(n_events) : 1;
  endfunction

endpackage

// File: rtl/perf_event_accum.sv
// rtl/perf_event_accum.sv - one event class: masked popcount, stage register, overflow-aware accumulator
//
// Purpose: sums one event's per-core pulses across enabled cores (stage 1) and adds
//          the registered increment into a saturating or wrapping accumulator (stage 2).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_pulse       : this event's pulse from each core
//   i_mask        : per-core contribution enable
//   i_count_en    : global count enable for pulses presented this cycle
//   i_clear       : zero accumulator, sticky overflow and stage-1 register
//   o_acc, o_ovf  : live accumulator and sticky overflow flag
//   o_nxt_acc,
//   o_nxt_ovf     : values the accumulator/flag take at the next edge if no clear
//                   occurs; the top captures these for atomic snapshots
module perf_event_accum
  import perf_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int CNT_WIDTH = 32,
  parameter int SAT_MODE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CORES-1:0] i_pulse,
  input  logic [NUM_CORES-1:0] i_mask,
  input  logic                 i_count_en,
  input  logic                 i_clear,
  output logic [CNT_WIDTH-1:0] o_acc,
  output logic                 o_ovf,
  output logic [CNT_WIDTH-1:0] o_nxt_acc,
  output logic                 o_nxt_ovf
);

  localparam int INC_W = inc_width(NUM_CORES);
  localparam int SUM_W = CNT_WIDTH + 1;

  logic [INC_W-1:0]     w_pop;
  logic [INC_W-1:0]     r_inc;
  logic [SUM_W-1:0]     w_sum;
  logic [CNT_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] w_nxt_acc;
  logic                 w_nxt_ovf;

  always_comb begin
    w_pop = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      w_pop = w_pop + INC_W'(i_pulse[c] & i_mask[c]);
    end
  end

  // Stage 1: pulses in a clear cycle are dropped along with the accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc <= '0;
    end else if (i_clear || !i_count_en) begin
      r_inc <= '0;
    end else begin
      r_inc <= w_pop;
    end
  end

  // One extra bit catches the carry out; it marks overflow in both modes.
  assign w_sum = {1'b0, r_acc} + SUM_W'(r_inc);

  always_comb begin
    w_nxt_acc = w_sum[CNT_WIDTH-1:0];
    if (w_sum[CNT_WIDTH] && (SAT_MODE != 0)) begin
      w_nxt_acc = '1;
    end
    w_nxt_ovf = r_ovf | w_sum[CNT_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_acc <= w_nxt_acc;
      r_ovf <= w_nxt_ovf;
    end
  end

  assign o_acc     = r_acc;
  assign o_ovf     = r_ovf;
  assign o_nxt_acc = w_nxt_acc;
  assign o_nxt_ovf = w_nxt_ovf;

endmodule

// File: rtl/perf_aggregator.sv
// rtl/perf_aggregator.sv - multi-core performance-event aggregator with snapshot shadow and read port
//
// Purpose: per-event accumulation of per-core pulses (one perf_event_accum per event),
//          atomic snapshot(-and-clear) into a shadow bank, and an indexed registered read port.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   evt_pulse            : bit [c*NUM_EVENTS+e] = event e on core c this cycle
//   core_mask, count_en  : per-core and global count enables
//   clear                : zero accumulators, overflow flags and in-flight increments
//   snap_req, snap_done  : capture live state into the shadow; done pulses the next cycle
//   live_count, ovf      : live accumulators (event e at [e*CNT_WIDTH +: CNT_WIDTH]) and sticky flags
//   rd_req, rd_sel       : shadow read request and event index
//   rd_ack, rd_data,
//   rd_ovf, rd_err       : read response one cycle after the request
module perf_aggregator
  import perf_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int NUM_EVENTS = 6,
  parameter int CNT_WIDTH  = 32,
  parameter int SAT_MODE   = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CORES*NUM_EVENTS-1:0] evt_pulse,
  input  logic [NUM_CORES-1:0]            core_mask,
  input  logic                            count_en,
  input  logic                            clear,
  input  logic                            snap_req,
  output logic                            snap_done,
  output logic [NUM_EVENTS*CNT_WIDTH-1:0] live_count,
  output logic [NUM_EVENTS-1:0]           ovf,
  input  logic                            rd_req,
  input  logic [sel_width(NUM_EVENTS)-1:0] rd_sel,
  output logic                            rd_ack,
  output logic [CNT_WIDTH-1:0]            rd_data,
  output logic                            rd_ovf,
  output logic                            rd_err
);

  localparam int SEL_W  = sel_width(NUM_EVENTS);
  localparam int SELX_W = SEL_W + 1;
  localparam logic [SELX_W-1:0] EVT_LIMIT = SELX_W'(NUM_EVENTS);

  logic [CNT_WIDTH-1:0]  w_nxt_acc [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] w_nxt_ovf;
  logic [CNT_WIDTH-1:0]  r_shadow  [NUM_EVENTS];
  logic [NUM_EVENTS-1:0] r_shadow_ovf;
  logic                  r_snap_done;
  logic                  r_rd_ack;
  logic [CNT_WIDTH-1:0]  r_rd_data;
  logic                  r_rd_ovf;
  logic                  r_rd_err;
  logic [CNT_WIDTH-1:0]  w_rd_val;
  logic                  w_rd_ovf;
  logic                  w_rd_err;

  for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_evt
    logic [NUM_CORES-1:0] w_pulse;

    always_comb begin
      w_pulse = '0;
      for (int c = 0; c < NUM_CORES; c++) begin
        w_pulse[c] = evt_pulse[c*NUM_EVENTS + e];
      end
    end

    perf_event_accum #(
      .NUM_CORES (NUM_CORES),
      .CNT_WIDTH (CNT_WIDTH),
      .SAT_MODE  (SAT_MODE)
    ) u_accum (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_pulse    (w_pulse),
      .i_mask     (core_mask),
      .i_count_en (count_en),
      .i_clear    (clear),
      .o_acc      (live_count[e*CNT_WIDTH +: CNT_WIDTH]),
      .o_ovf      (ovf[e]),
      .o_nxt_acc  (w_nxt_acc[e]),
      .o_nxt_ovf  (w_nxt_ovf[e])
    );
  end

  // The shadow takes the no-clear next state, so snap_req with clear captures
  // the full pre-clear total including the increment still in stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_EVENTS; e++) begin
        r_shadow[e] <= '0;
      end
      r_shadow_ovf <= '0;
      r_snap_done  <= 1'b0;
    end else begin
      r_snap_done <= snap_req;
      if (snap_req) begin
        for (int e = 0; e < NUM_EVENTS; e++) begin
          r_shadow[e] <= w_nxt_acc[e];
        end
        r_shadow_ovf <= w_nxt_ovf;
      end
    end
  end

  // Out-of-range indices match no entry and read as zero.
  always_comb begin
    w_rd_val = '0;
    w_rd_ovf = 1'b0;
    for (int e = 0; e < NUM_EVENTS; e++) begin
      if (rd_sel == SEL_W'(e)) begin
        w_rd_val = r_shadow[e];
        w_rd_ovf = r_shadow_ovf[e];
      end
    end
  end

  assign w_rd_err = ({1'b0, rd_sel} >= EVT_LIMIT);

  // Reads sample the shadow before a same-edge snapshot lands, returning the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ack  <= 1'b0;
      r_rd_data <= '0;
      r_rd_ovf  <= 1'b0;
      r_rd_err  <= 1'b0;
    end else if (rd_req) begin
      r_rd_ack  <= 1'b1;
      r_rd_err  <= w_rd_err;
      r_rd_data <= w_rd_err ? '0 : w_rd_val;
      r_rd_ovf  <= w_rd_err ? 1'b0 : w_rd_ovf;
    end else begin
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end
  end

  assign snap_done = r_snap_done;
  assign rd_ack    = r_rd_ack;
  assign rd_data   = r_rd_data;
  assign rd_ovf    = r_rd_ovf;
  assign rd_err    = r_rd_err;

endmodule
